// File: rtl/ofmi_pkg.sv
// Shared definitions for the OFMI master sequencer: state encoding, handshake
// polarity common with the OFMI state machine, and the registered output bundle.
package ofmi_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_W_LOAD,
        ST_ACK_LOAD,
        ST_FEED,
        ST_PAUSE,
        ST_ACK_FEED,
        ST_WAIT_RES,
        ST_W_WRITE,
        ST_ACK_WRITE,
        ST_ERROR
    } state_e;

    localparam logic HS_ON  = 1'b1;
    localparam logic HS_OFF = 1'b0;

    typedef struct packed {
        logic start_load;
        logic load_ok;
        logic start_feed;
        logic stop_feed;
        logic feed_ok;
        logic start_write;
        logic write_ok;
        logic done;
    } hs_out_t;

    localparam hs_out_t HS_NONE = '0;

    function automatic logic is_busy(input state_e s);
        return !((s == ST_IDLE) || (s == ST_ERROR));
    endfunction

    // WAIT_RES is excluded: the datapath may take arbitrarily long to produce results.
    function automatic logic wdog_counts(input state_e s);
        case (s)
            ST_W_LOAD, ST_ACK_LOAD, ST_FEED, ST_PAUSE,
            ST_ACK_FEED, ST_W_WRITE, ST_ACK_WRITE: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ofmi_watchdog.sv
// Cycle counter with synchronous clear and enable; flags the cycle in which
// the TERM-th consecutive enabled cycle is reached.
module ofmi_watchdog #(
    parameter int TO_W = 16,
    parameter int TERM = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TERM - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;

    assign tc = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (!tc) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ofmi_master.sv
// Master-side sequencer for the OFMI: weight load, then per tile a feed and a
// write-back, with back-pressure pause/resume and a per-wait watchdog.
module ofmi_master
    import ofmi_pkg::*;
#(
    parameter int NUM_TILES      = 4,
    parameter int TILE_W         = 8,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TO_W           = 16
) (
    input  logic              OFMI_MASTER_Clk,
    input  logic              OFMI_MASTER_Reset,
    input  logic              OFMI_MASTER_Go,
    input  logic              OFMI_MASTER_Almost_Full,
    input  logic              OFMI_MASTER_Results_Ready,
    input  logic              OFMI_MASTER_Loading_Weights_Already,
    input  logic              OFMI_MASTER_Feeding_Datapath_finished,
    input  logic              OFMI_MASTER_Writing_Data_Already,
    output logic              OFMI_MASTER_Start_Loading_Weights,
    output logic              OFMI_MASTER_Loading_Weights_Already_Ok,
    output logic              OFMI_MASTER_Start_Feeding_Datapath,
    output logic              OFMI_MASTER_Stop_Feeding_Datapath,
    output logic              OFMI_MASTER_Feeding_Datapath_finished_OK,
    output logic              OFMI_MASTER_Start_Writing_Data,
    output logic              OFMI_MASTER_Writing_Data_Already_Ok,
    output logic [TILE_W-1:0] OFMI_MASTER_Tile_Index,
    output logic              OFMI_MASTER_Busy,
    output logic              OFMI_MASTER_Done,
    output logic              OFMI_MASTER_Error
);

    localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);

    state_e              state_q, state_d;
    hs_out_t             hs_q, hs_d;
    logic [TILE_W-1:0]   tile_q, tile_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic                wd_clr, wd_en, wd_tc;

    logic go, almost_full, results_ready, ld_already, feed_fin, wr_already;

    assign go            = OFMI_MASTER_Go;
    assign almost_full   = OFMI_MASTER_Almost_Full;
    assign results_ready = OFMI_MASTER_Results_Ready;
    assign ld_already    = OFMI_MASTER_Loading_Weights_Already;
    assign feed_fin      = OFMI_MASTER_Feeding_Datapath_finished;
    assign wr_already    = OFMI_MASTER_Writing_Data_Already;

    assign wd_en  = wdog_counts(state_q);
    assign wd_clr = (state_d != state_q);

    ofmi_watchdog #(
        .TO_W (TO_W),
        .TERM (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (OFMI_MASTER_Clk),
        .rst_n (OFMI_MASTER_Reset),
        .clr   (wd_clr),
        .en    (wd_en),
        .tc    (wd_tc)
    );

    always_comb begin
        state_d = state_q;
        hs_d    = HS_NONE;
        tile_d  = tile_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    hs_d.start_load = 1'b1;
                    state_d         = ST_W_LOAD;
                end
            end
            ST_W_LOAD: begin
                if (ld_already == HS_ON) begin
                    hs_d.load_ok = 1'b1;
                    state_d      = ST_ACK_LOAD;
                end
            end
            ST_ACK_LOAD: begin
                if (ld_already == HS_OFF) begin
                    hs_d.start_feed = 1'b1;
                    state_d         = ST_FEED;
                end else begin
                    hs_d.load_ok = 1'b1;
                end
            end
            // Completion wins over back-pressure so a finished feed is never stalled.
            ST_FEED: begin
                if (feed_fin == HS_ON) begin
                    hs_d.feed_ok = 1'b1;
                    state_d      = ST_ACK_FEED;
                end else if (almost_full) begin
                    hs_d.stop_feed = 1'b1;
                    state_d        = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (feed_fin == HS_ON) begin
                    hs_d.feed_ok = 1'b1;
                    state_d      = ST_ACK_FEED;
                end else if (almost_full) begin
                    hs_d.stop_feed = 1'b1;
                end else begin
                    hs_d.start_feed = 1'b1;
                    state_d         = ST_FEED;
                end
            end
            ST_ACK_FEED: begin
                if (feed_fin == HS_OFF) begin
                    state_d = ST_WAIT_RES;
                end else begin
                    hs_d.feed_ok = 1'b1;
                end
            end
            ST_WAIT_RES: begin
                if (results_ready) begin
                    hs_d.start_write = 1'b1;
                    state_d          = ST_W_WRITE;
                end
            end
            ST_W_WRITE: begin
                if (wr_already == HS_ON) begin
                    hs_d.write_ok = 1'b1;
                    state_d       = ST_ACK_WRITE;
                end
            end
            // Weights stay resident, so the next tile goes straight back to feeding.
            ST_ACK_WRITE: begin
                if (wr_already == HS_ON) begin
                    hs_d.write_ok = 1'b1;
                end else if (tile_q == LAST_TILE) begin
                    hs_d.done = 1'b1;
                    tile_d    = '0;
                    state_d   = ST_IDLE;
                end else begin
                    hs_d.start_feed = 1'b1;
                    tile_d          = tile_q + TILE_W'(1);
                    state_d         = ST_FEED;
                end
            end
            ST_ERROR: begin
                if (go) begin
                    err_d   = 1'b0;
                    tile_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (wd_tc) begin
            hs_d    = HS_NONE;
            err_d   = 1'b1;
            tile_d  = tile_q;
            state_d = ST_ERROR;
        end

        busy_d = is_busy(state_d);
    end

    always_ff @(posedge OFMI_MASTER_Clk or negedge OFMI_MASTER_Reset) begin
        if (!OFMI_MASTER_Reset) begin
            state_q <= ST_IDLE;
            hs_q    <= HS_NONE;
            tile_q  <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hs_q    <= hs_d;
            tile_q  <= tile_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign OFMI_MASTER_Start_Loading_Weights        = hs_q.start_load;
    assign OFMI_MASTER_Loading_Weights_Already_Ok   = hs_q.load_ok;
    assign OFMI_MASTER_Start_Feeding_Datapath       = hs_q.start_feed;
    assign OFMI_MASTER_Stop_Feeding_Datapath        = hs_q.stop_feed;
    assign OFMI_MASTER_Feeding_Datapath_finished_OK = hs_q.feed_ok;
    assign OFMI_MASTER_Start_Writing_Data           = hs_q.start_write;
    assign OFMI_MASTER_Writing_Data_Already_Ok      = hs_q.write_ok;
    assign OFMI_MASTER_Done                         = hs_q.done;
    assign OFMI_MASTER_Tile_Index                   = tile_q;
    assign OFMI_MASTER_Busy                         = busy_q;
    assign OFMI_MASTER_Error                        = err_q;

endmodule

// File: tb/tb_ofmi_master.sv
// Bench for ofmi_master: directed vector table, corner sequences, and a
// randomized OFMI responder with a transaction-level scoreboard.
module tb_ofmi_master;

    localparam int NT = 2;
    localparam int TW = 8;
    localparam int TO = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, go, af, rr, la, ff, wa;
    logic sl, lo, sf, st, fo, sw, wo, busy, done, err;
    logic [TW-1:0] tile;

    int checks = 0;
    int errors = 0;

    ofmi_master #(
        .NUM_TILES      (NT),
        .TILE_W         (TW),
        .TIMEOUT_CYCLES (TO),
        .TO_W           (16)
    ) dut (
        .OFMI_MASTER_Clk                          (clk),
        .OFMI_MASTER_Reset                        (rst_n),
        .OFMI_MASTER_Go                           (go),
        .OFMI_MASTER_Almost_Full                  (af),
        .OFMI_MASTER_Results_Ready                (rr),
        .OFMI_MASTER_Loading_Weights_Already      (la),
        .OFMI_MASTER_Feeding_Datapath_finished    (ff),
        .OFMI_MASTER_Writing_Data_Already         (wa),
        .OFMI_MASTER_Start_Loading_Weights        (sl),
        .OFMI_MASTER_Loading_Weights_Already_Ok   (lo),
        .OFMI_MASTER_Start_Feeding_Datapath       (sf),
        .OFMI_MASTER_Stop_Feeding_Datapath        (st),
        .OFMI_MASTER_Feeding_Datapath_finished_OK (fo),
        .OFMI_MASTER_Start_Writing_Data           (sw),
        .OFMI_MASTER_Writing_Data_Already_Ok      (wo),
        .OFMI_MASTER_Tile_Index                   (tile),
        .OFMI_MASTER_Busy                         (busy),
        .OFMI_MASTER_Done                         (done),
        .OFMI_MASTER_Error                        (err)
    );

    // Output bundle order: sl lo sf st fo sw wo busy done err
    function automatic logic [9:0] outs();
        return {sl, lo, sf, st, fo, sw, wo, busy, done, err};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Input vector order: go af rr la ff wa
    task automatic drive(input logic [5:0] v);
        {go, af, rr, la, ff, wa} = v;
    endtask

    task automatic do_reset();
        drive(6'b0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // From IDLE: go, weight handshake, one feed, landing in WAIT_RES.
    task automatic to_wait_res();
        drive(6'b100000); tick();
        drive(6'b000100); tick();
        drive(6'b000000); tick();
        drive(6'b000010); tick();
        drive(6'b000000); tick();
    endtask

    typedef struct {
        logic [5:0]    in;
        logic [9:0]    exp;
        logic [TW-1:0] tile;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [5:0] i, input logic [9:0] e, input int t);
        vec_t v;
        v.in   = i;
        v.exp  = e;
        v.tile = TW'(t);
        return v;
    endfunction

    // Random-phase responder and scoreboard state
    int ld_w, fd_left, rr_w, wr_w, af_run;
    bit feeding, af_prev, st_prev, go_prev;
    int n_sl, n_fs, n_sw, exp_tile, jobs;

    task automatic rand_step();
        chk("pulse_ack_overlap", 32'((sl | sf | sw) & (lo | fo | wo)), 0);
        chk("stop_without_af", 32'(st & ~af_prev), 0);
        chk("error_in_random", 32'(err), 0);
        if (sl) n_sl++;
        if (sf && !st_prev) n_fs++;
        if (sf && st_prev) chk("resume_with_af_high", 32'(af_prev), 0);
        if (sw) begin
            chk("tile_at_write", 32'(tile), 32'(exp_tile));
            exp_tile++;
            n_sw++;
        end
        if (done) begin
            chk("job_loads", n_sl, 1);
            chk("job_feed_starts", n_fs, NT);
            chk("job_writes", n_sw, NT);
            chk("tile_after_done", 32'(tile), 0);
            jobs++;
            n_sl = 0; n_fs = 0; n_sw = 0; exp_tile = 0;
        end
        st_prev = st;

        if (sl) ld_w = $urandom_range(1, 4);
        else if (ld_w > 0) begin
            ld_w--;
            if (ld_w == 0) la = 1'b1;
        end
        if (la && lo) la = 1'b0;

        if (sf && !feeding && !ff) begin
            feeding = 1'b1;
            fd_left = $urandom_range(1, 5);
        end else if (feeding && !st) begin
            fd_left--;
            if (fd_left == 0) begin
                ff      = 1'b1;
                feeding = 1'b0;
            end
        end

        if (ff && fo) begin
            ff   = 1'b0;
            rr_w = $urandom_range(1, 25);
        end else if (rr_w > 0) begin
            rr_w--;
            if (rr_w == 0) rr = 1'b1;
        end
        if (sw) rr = 1'b0;

        if (sw) wr_w = $urandom_range(1, 4);
        else if (wr_w > 0) begin
            wr_w--;
            if (wr_w == 0) wa = 1'b1;
        end
        if (wa && wo) wa = 1'b0;

        if (af_run > 0) begin
            af = 1'b1;
            af_run--;
        end else if ($urandom_range(0, 5) == 0) begin
            af     = 1'b1;
            af_run = $urandom_range(0, 3);
        end else begin
            af = 1'b0;
        end
        af_prev = af;

        go      = !busy && !go_prev && ($urandom_range(0, 3) == 0);
        go_prev = go;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(6'b0);
        @(negedge clk);
        chk("reset_outs", 32'(outs()), 0);
        chk("reset_tile", 32'(tile), 0);
        do_reset();

        // Full two-tile job with pause/resume, simultaneous AF+finish, ignored Go
        tbl.push_back(mk(6'b000000, 10'b0000000000, 0));
        tbl.push_back(mk(6'b100000, 10'b1000000100, 0));
        tbl.push_back(mk(6'b000000, 10'b0000000100, 0));
        tbl.push_back(mk(6'b000100, 10'b0100000100, 0));
        tbl.push_back(mk(6'b000100, 10'b0100000100, 0));
        tbl.push_back(mk(6'b000000, 10'b0010000100, 0));
        tbl.push_back(mk(6'b010000, 10'b0001000100, 0));
        tbl.push_back(mk(6'b010000, 10'b0001000100, 0));
        tbl.push_back(mk(6'b000000, 10'b0010000100, 0));
        tbl.push_back(mk(6'b100000, 10'b0000000100, 0));
        tbl.push_back(mk(6'b010010, 10'b0000100100, 0));
        tbl.push_back(mk(6'b000010, 10'b0000100100, 0));
        tbl.push_back(mk(6'b000000, 10'b0000000100, 0));
        tbl.push_back(mk(6'b000000, 10'b0000000100, 0));
        tbl.push_back(mk(6'b001000, 10'b0000010100, 0));
        tbl.push_back(mk(6'b100000, 10'b0000000100, 0));
        tbl.push_back(mk(6'b000001, 10'b0000001100, 0));
        tbl.push_back(mk(6'b000000, 10'b0010000100, 1));
        tbl.push_back(mk(6'b010000, 10'b0001000100, 1));
        tbl.push_back(mk(6'b010010, 10'b0000100100, 1));
        tbl.push_back(mk(6'b000000, 10'b0000000100, 1));
        tbl.push_back(mk(6'b001000, 10'b0000010100, 1));
        tbl.push_back(mk(6'b000001, 10'b0000001100, 1));
        tbl.push_back(mk(6'b000001, 10'b0000001100, 1));
        tbl.push_back(mk(6'b000000, 10'b0000000010, 0));
        tbl.push_back(mk(6'b000000, 10'b0000000000, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].in);
            tick();
            chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(tbl[i].exp));
            chk($sformatf("vec%0d_tile", i), 32'(tile), 32'(tbl[i].tile));
        end

        // Almost_Full high for 5 cycles mid-feed
        do_reset();
        drive(6'b100000); tick();
        drive(6'b000100); tick();
        drive(6'b000000); tick();
        chk("af5_feed_start", 32'({sf, st}), 32'(2'b10));
        for (int k = 0; k < 5; k++) begin
            drive(6'b010000); tick();
            chk($sformatf("af5_stop_c%0d", k), 32'({sf, st}), 32'(2'b01));
        end
        drive(6'b000000); tick();
        chk("af5_resume", 32'({sf, st}), 32'(2'b10));
        tick();
        chk("af5_single_resume", 32'({sf, st}), 0);

        // Results_Ready held low in WAIT_RES longer than the watchdog limit
        do_reset();
        to_wait_res();
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("rr_low_c%0d", k), 32'({sw, busy, err}), 32'(3'b010));
        end
        drive(6'b001000); tick();
        chk("rr_rise_write", 32'({sw, busy, err}), 32'(3'b110));

        // Watchdog in W_LOAD, then Go clears Error without starting a job
        do_reset();
        drive(6'b100000); tick();
        drive(6'b000000);
        for (int k = 1; k <= TO; k++) begin
            tick();
            if (k < TO) chk($sformatf("wd_wait_c%0d", k), 32'({busy, err}), 32'(2'b10));
            else        chk("wd_timeout_outs", 32'(outs()), 32'(10'b0000000001));
        end
        drive(6'b100000); tick();
        chk("err_clear_go", 32'(outs()), 0);
        drive(6'b000000); tick();
        chk("err_clear_no_start", 32'(outs()), 0);
        chk("err_clear_tile", 32'(tile), 0);

        // Asynchronous reset while in ACK_WRITE of the second tile
        do_reset();
        to_wait_res();
        drive(6'b001000); tick();
        drive(6'b000001); tick();
        drive(6'b000000); tick();
        drive(6'b000010); tick();
        drive(6'b000000); tick();
        drive(6'b001000); tick();
        drive(6'b000001); tick();
        chk("ackwr_before_reset", 32'({wo, tile}), 32'({1'b1, 8'd1}));
        #2;
        rst_n = 1'b0;
        drive(6'b000000);
        #1;
        chk("async_reset_outs", 32'(outs()), 0);
        chk("async_reset_tile", 32'(tile), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(6'b100000); tick();
        chk("restart_load", 32'({sl, busy}), 32'(2'b11));

        // Randomized jobs against the responder/scoreboard
        do_reset();
        ld_w = 0; fd_left = 0; rr_w = 0; wr_w = 0; af_run = 0;
        feeding = 0; af_prev = 0; st_prev = 0; go_prev = 0;
        n_sl = 0; n_fs = 0; n_sw = 0; exp_tile = 0; jobs = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            rand_step();
        end
        chk("random_jobs_completed", 32'(jobs >= 5), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
